// File: rtl/bt_paddle_ctrl.sv
// Paddle controller fed by the Bluetooth UART receiver: decodes command bytes into
// direction/speed, moves the paddle once per frame with clamping, and auto-stops on link silence.
module bt_paddle_ctrl #(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 640,
    parameter int PADDLE_W       = 80,
    parameter int STEP_UNIT      = 2,
    parameter int TIMEOUT_FRAMES = 120,
    parameter int SPEED_RST      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       frame_tick,
    output logic [9:0] paddle_x,
    output logic [1:0] dir,
    output logic [3:0] speed_lvl,
    output logic       cmd_err
);

    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [10:0] X_LO     = 11'(X_MIN);
    localparam logic [10:0] X_HI     = 11'(X_MAX - PADDLE_W);
    localparam logic [9:0]  CENTER_X = 10'((X_MIN + X_MAX - PADDLE_W) / 2);
    localparam logic [TW-1:0] TO_CNT = TW'(TIMEOUT_FRAMES);
    localparam logic [1:0] DIR_STOP  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;

    logic [9:0]    px_q, px_d;
    logic [1:0]    dir_q, dir_d;
    logic [3:0]    speed_q, speed_d;
    logic          err_q, err_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          cmd_ok_s, cmd_dir_en_s, cmd_speed_en_s, cmd_center_s;
    logic [1:0]    cmd_dir_s;
    logic [10:0]   step_s, px_ext_s;

    // Byte decode into command fields
    always_comb begin
        cmd_ok_s       = 1'b1;
        cmd_dir_en_s   = 1'b0;
        cmd_speed_en_s = 1'b0;
        cmd_center_s   = 1'b0;
        cmd_dir_s      = DIR_STOP;
        case (rx_data)
            8'h4C: begin cmd_dir_en_s = 1'b1; cmd_dir_s = DIR_LEFT;  end
            8'h52: begin cmd_dir_en_s = 1'b1; cmd_dir_s = DIR_RIGHT; end
            8'h53: begin cmd_dir_en_s = 1'b1; cmd_dir_s = DIR_STOP;  end
            8'h43: begin cmd_dir_en_s = 1'b1; cmd_dir_s = DIR_STOP; cmd_center_s = 1'b1; end
            default: begin
                if (rx_data >= 8'h31 && rx_data <= 8'h39) begin
                    cmd_speed_en_s = 1'b1;
                end else begin
                    cmd_ok_s = 1'b0;
                end
            end
        endcase
    end

    // Frame movement and timeout first, then commands override (they win on conflicts)
    always_comb begin
        px_d     = px_q;
        dir_d    = dir_q;
        speed_d  = speed_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        step_s   = 11'(speed_q) * 11'(STEP_UNIT);
        px_ext_s = {1'b0, px_q};

        if (frame_tick) begin
            case (dir_q)
                DIR_LEFT: begin
                    if (px_ext_s < X_LO + step_s) px_d = X_LO[9:0];
                    else                          px_d = 10'(px_ext_s - step_s);
                end
                DIR_RIGHT: begin
                    if (px_ext_s + step_s > X_HI) px_d = X_HI[9:0];
                    else                          px_d = 10'(px_ext_s + step_s);
                end
                default: px_d = px_q;
            endcase
        end else begin
            px_d = px_q;
        end

        if (dir_q == DIR_STOP) begin
            cnt_d = {TW{1'b0}};
        end else if (frame_tick && cnt_q != TO_CNT) begin
            cnt_d = cnt_q + TW'(1);
            if (cnt_d == TO_CNT) dir_d = DIR_STOP;
            else                 dir_d = dir_q;
        end else begin
            cnt_d = cnt_q;
        end

        if (rx_valid && cmd_ok_s) begin
            cnt_d = {TW{1'b0}};
            if (cmd_dir_en_s) dir_d = cmd_dir_s;
            else              dir_d = dir_q;
            if (cmd_speed_en_s) speed_d = rx_data[3:0];
            else                speed_d = speed_q;
            if (cmd_center_s) px_d = CENTER_X;
            else              px_d = px_d;
        end else begin
            err_d = rx_valid;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            px_q    <= CENTER_X;
            dir_q   <= DIR_STOP;
            speed_q <= 4'(SPEED_RST);
            err_q   <= 1'b0;
            cnt_q   <= {TW{1'b0}};
        end else begin
            px_q    <= px_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign paddle_x  = px_q;
    assign dir       = dir_q;
    assign speed_lvl = speed_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_bt_paddle_ctrl.sv
// Directed bench for bt_paddle_ctrl (timeout shortened to 4 frames).
module tb_bt_paddle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] paddle_x;
    logic [1:0] dir;
    logic [3:0] speed_lvl;
    logic       cmd_err;

    int total = 0;
    int bad   = 0;
    int exp_x;

    bt_paddle_ctrl #(.TIMEOUT_FRAMES(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_tick(frame_tick), .paddle_x(paddle_x), .dir(dir),
        .speed_lvl(speed_lvl), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; returns #1 after the edge with strobes cleared.
    task automatic step(input logic v, input logic [7:0] d, input logic ft);
        rx_valid = v; rx_data = d; frame_tick = ft;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; frame_tick = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        chk("rst_x", paddle_x, 280);
        chk("rst_dir", dir, 0);
        chk("rst_spd", speed_lvl, 3);
        chk("rst_err", cmd_err, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("idle_x", paddle_x, 280);
            chk("idle_dir", dir, 0);
            chk("idle_err", cmd_err, 0);
        end

        // right at speed 3; timeout of 4 stops after the 4th frame
        step(1'b1, 8'h52, 1'b0);
        chk("r_dir", dir, 2);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("r_x", paddle_x, 280 + 6 * i);
        end
        chk("r_to_dir", dir, 0);

        // right clamp at speed 9
        step(1'b1, 8'h39, 1'b0);
        chk("spd9", speed_lvl, 9);
        exp_x = 304;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) step(1'b1, 8'h52, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            exp_x = (exp_x + 18 > 560) ? 560 : exp_x + 18;
            chk("clampR_x", paddle_x, exp_x);
        end
        chk("clampR_end", paddle_x, 560);

        // centre, then left down to 10 and clamp at 0
        step(1'b1, 8'h43, 1'b0);
        chk("c_x", paddle_x, 280);
        chk("c_dir", dir, 0);
        exp_x = 280;
        for (int i = 0; i < 17; i++) begin
            if (i % 3 == 0) step(1'b1, 8'h4C, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            exp_x = (exp_x < 18) ? 0 : exp_x - 18;
            chk("clampL_x", paddle_x, exp_x);
            if (i == 14) chk("clampL_10", paddle_x, 10);
        end
        chk("clampL_end", paddle_x, 0);

        // bad byte
        step(1'b1, 8'h52, 1'b0);
        step(1'b1, 8'h41, 1'b0);
        chk("err_hi", cmd_err, 1);
        chk("err_dir", dir, 2);
        chk("err_spd", speed_lvl, 9);
        chk("err_x", paddle_x, 0);
        step(1'b0, 8'h00, 1'b0);
        chk("err_lo", cmd_err, 0);

        // 'C' with frame_tick: centring wins
        step(1'b1, 8'h43, 1'b1);
        chk("cft_x", paddle_x, 280);
        chk("cft_dir", dir, 0);

        // back-to-back speed commands, last wins
        step(1'b1, 8'h35, 1'b0);
        step(1'b1, 8'h37, 1'b0);
        chk("b2b_spd", speed_lvl, 7);
        step(1'b1, 8'h33, 1'b0);
        chk("spd3", speed_lvl, 3);

        // timeout
        step(1'b1, 8'h4C, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("to_x", paddle_x, 280 - 6 * i);
            chk("to_dir", dir, (i == 4) ? 0 : 1);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("to_5th_x", paddle_x, 256);

        // re-sending 'L' restarts the count
        step(1'b1, 8'h4C, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("rl_x1", paddle_x, 238);
        step(1'b1, 8'h4C, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("rl_x2", paddle_x, 220);
        chk("rl_dir", dir, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("rl_x3", paddle_x, 214);
        chk("rl_dir_to", dir, 0);

        // 'R' with frame_tick from stop: takes effect next frame
        step(1'b1, 8'h52, 1'b1);
        chk("rft_x", paddle_x, 214);
        chk("rft_dir", dir, 2);
        step(1'b0, 8'h00, 1'b1);
        chk("rft_x2", paddle_x, 220);
        step(1'b0, 8'h00, 1'b1);
        chk("rft_x3", paddle_x, 226);

        // reset mid-motion overrides command and frame
        rst = 1'b1;
        step(1'b1, 8'h41, 1'b1);
        chk("mrst_x", paddle_x, 280);
        chk("mrst_dir", dir, 0);
        chk("mrst_spd", speed_lvl, 3);
        chk("mrst_err", cmd_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
